// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared state type and per-channel step
// arithmetic for the LED fade sequencer.
package led_fade_pkg;

    localparam int c_filament_value_width = 8;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } t_fade_state;

    // 9-bit differences keep large steps from wrapping or overshooting
    function automatic logic [7:0] step_toward(
        input logic [7:0] cur,
        input logic [7:0] tgt,
        input logic [7:0] step
    );
        logic [8:0] diff;
        logic [7:0] res;
        diff = 9'd0;
        res  = cur;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            res  = (diff > {1'b0, step}) ? cur + step : tgt;
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            res  = (diff > {1'b0, step}) ? cur - step : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/led_fade_tick_gen.sv
// led_fade_tick_gen: free-running down counter that
// flags one cycle per fade step period.
module led_fade_tick_gen #(
    parameter int parm_FCLK                     = 40_000_000,
    parameter int parm_step_period_microseconds = 1000
) (
    input  logic i_clk,
    input  logic i_srst_n,
    output logic o_tick
);

    localparam int c_step_count =
        parm_FCLK / 1_000_000 * parm_step_period_microseconds;
    localparam int c_cw =
        (c_step_count > 1) ? $clog2(c_step_count) : 1;
    localparam logic [c_cw-1:0] c_reload = c_cw'(c_step_count - 1);

    logic [c_cw-1:0] count;

    assign o_tick = (count == '0);

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            count <= c_reload;
        end else if (count == '0) begin
            count <= c_reload;
        end else begin
            count <= count - c_cw'(1);
        end
    end

endmodule

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: accepts per-LED targets and ramps the
// current values toward them with a time-shared scan engine.
module led_fade_sequencer
    import led_fade_pkg::*;
#(
    parameter int parm_color_led_count          = 4,
    parameter int parm_basic_led_count          = 4,
    parameter int parm_FCLK                     = 40_000_000,
    parameter int parm_step_period_microseconds = 1000,
    parameter int parm_step_size                = 1
) (
    input  logic i_clk,
    input  logic i_srst_n,
    input  logic i_cmd_valid,
    output logic o_cmd_ready,
    input  logic [$clog2(parm_color_led_count+parm_basic_led_count)-1:0]
                 i_cmd_index,
    input  logic [7:0] i_cmd_red,
    input  logic [7:0] i_cmd_green,
    input  logic [7:0] i_cmd_blue,
    input  logic [7:0] i_cmd_lumin,
    input  logic i_cmd_instant,
    output logic o_cmd_error,
    output logic [c_filament_value_width*parm_color_led_count-1:0]
                 o_color_led_red_value,
    output logic [c_filament_value_width*parm_color_led_count-1:0]
                 o_color_led_green_value,
    output logic [c_filament_value_width*parm_color_led_count-1:0]
                 o_color_led_blue_value,
    output logic [c_filament_value_width*parm_basic_led_count-1:0]
                 o_basic_led_lumin_value,
    output logic o_fade_busy
);

    localparam int c_n  = parm_color_led_count;
    localparam int c_nm = parm_color_led_count + parm_basic_led_count;
    localparam int c_w  = $clog2(c_nm);
    localparam int c_fw = c_filament_value_width;
    localparam int c_step_count =
        parm_FCLK / 1_000_000 * parm_step_period_microseconds;
    localparam logic [7:0] c_step = 8'(parm_step_size);

    if (c_step_count <= c_nm + 2) begin : g_bad_period
        $error("step period too short for one full scan");
    end

    // basic LEDs keep their lumin in the red lane; green/blue stay 0
    logic [7:0] cur_r [c_nm];
    logic [7:0] cur_g [c_nm];
    logic [7:0] cur_b [c_nm];
    logic [7:0] tgt_r [c_nm];
    logic [7:0] tgt_g [c_nm];
    logic [7:0] tgt_b [c_nm];

    t_fade_state    state;
    logic [c_w-1:0] scan_idx;
    logic           tick_pending;
    logic           tick;
    logic           accept;
    logic           idx_color;
    logic           idx_basic;
    logic           any_diff;

    led_fade_tick_gen #(
        .parm_FCLK                     (parm_FCLK),
        .parm_step_period_microseconds (parm_step_period_microseconds)
    ) u_tick (
        .i_clk    (i_clk),
        .i_srst_n (i_srst_n),
        .o_tick   (tick)
    );

    assign o_cmd_ready = (state == ST_IDLE) && !tick_pending;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign idx_color   = 32'(i_cmd_index) < 32'(c_n);
    assign idx_basic   = !idx_color && (32'(i_cmd_index) < 32'(c_nm));

    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < c_nm; i++) begin
            if (cur_r[i] != tgt_r[i] || cur_g[i] != tgt_g[i] ||
                cur_b[i] != tgt_b[i]) begin
                any_diff = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            for (int i = 0; i < c_nm; i++) begin
                cur_r[i] <= '0;
                cur_g[i] <= '0;
                cur_b[i] <= '0;
                tgt_r[i] <= '0;
                tgt_g[i] <= '0;
                tgt_b[i] <= '0;
            end
            state        <= ST_IDLE;
            scan_idx     <= '0;
            tick_pending <= 1'b0;
            o_cmd_error  <= 1'b0;
            o_fade_busy  <= 1'b0;
        end else begin
            o_fade_busy <= any_diff;
            o_cmd_error <= accept && !idx_color && !idx_basic;
            if (tick) begin
                tick_pending <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (tick_pending) begin
                        tick_pending <= tick;
                        scan_idx     <= '0;
                        state        <= ST_SCAN;
                    end else if (accept) begin
                        unique case (1'b1)
                            idx_color: begin
                                tgt_r[i_cmd_index] <= i_cmd_red;
                                tgt_g[i_cmd_index] <= i_cmd_green;
                                tgt_b[i_cmd_index] <= i_cmd_blue;
                                if (i_cmd_instant) begin
                                    cur_r[i_cmd_index] <= i_cmd_red;
                                    cur_g[i_cmd_index] <= i_cmd_green;
                                    cur_b[i_cmd_index] <= i_cmd_blue;
                                end
                            end
                            idx_basic: begin
                                tgt_r[i_cmd_index] <= i_cmd_lumin;
                                if (i_cmd_instant) begin
                                    cur_r[i_cmd_index] <= i_cmd_lumin;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SCAN: begin
                    cur_r[scan_idx] <= step_toward(
                        cur_r[scan_idx], tgt_r[scan_idx], c_step);
                    cur_g[scan_idx] <= step_toward(
                        cur_g[scan_idx], tgt_g[scan_idx], c_step);
                    cur_b[scan_idx] <= step_toward(
                        cur_b[scan_idx], tgt_b[scan_idx], c_step);
                    if (scan_idx == c_w'(c_nm - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        scan_idx <= scan_idx + c_w'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < c_n; k++) begin : g_color
        assign o_color_led_red_value[c_fw*k +: c_fw]   = cur_r[k];
        assign o_color_led_green_value[c_fw*k +: c_fw] = cur_g[k];
        assign o_color_led_blue_value[c_fw*k +: c_fw]  = cur_b[k];
    end

    for (genvar j = 0; j < parm_basic_led_count; j++) begin : g_basic
        assign o_basic_led_lumin_value[c_fw*j +: c_fw] = cur_r[c_n+j];
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb_led_fade_sequencer: scoreboard bench with a whole-scan
// reference model; index 7 is the out-of-range index here.
module tb_led_fade_sequencer;

    localparam int N      = 4;
    localparam int M      = 3;
    localparam int NM     = N + M;
    localparam int STEP   = 3;
    localparam int PERIOD = 100;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
        logic [23:0] l;
        logic        busy;
        logic        err;
    } snap_t;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        valid = 1'b0;
    logic        instant = 1'b0;
    logic [2:0]  idx = '0;
    logic [7:0]  red = '0, grn = '0, blu = '0, lum = '0;
    logic        ready, err, busy;
    logic [31:0] r_bus, g_bus, b_bus;
    logic [23:0] l_bus;

    led_fade_sequencer #(
        .parm_color_led_count          (N),
        .parm_basic_led_count          (M),
        .parm_FCLK                     (1_000_000),
        .parm_step_period_microseconds (PERIOD),
        .parm_step_size                (STEP)
    ) dut (
        .i_clk                   (clk),
        .i_srst_n                (srst_n),
        .i_cmd_valid             (valid),
        .o_cmd_ready             (ready),
        .i_cmd_index             (idx),
        .i_cmd_red               (red),
        .i_cmd_green             (grn),
        .i_cmd_blue              (blu),
        .i_cmd_lumin             (lum),
        .i_cmd_instant           (instant),
        .o_cmd_error             (err),
        .o_color_led_red_value   (r_bus),
        .o_color_led_green_value (g_bus),
        .o_color_led_blue_value  (b_bus),
        .o_basic_led_lumin_value (l_bus),
        .o_fade_busy             (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int mr[NM], mg[NM], mb[NM];
    int tr[NM], tg[NM], t_b[NM];
    snap_t cmd_q[$];
    snap_t scan_q[$];

    bit mon_en = 0, acc_prev = 0, rdy_prev = 1;
    bit busy_chk = 0, err_chk = 0, exp_busy = 0;
    int run = 0, last_drop = 0, last_rise = -1, scan_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_snap(input string nm, input snap_t s);
        check({nm, "_red"}, r_bus, s.r);
        check({nm, "_green"}, g_bus, s.g);
        check({nm, "_blue"}, b_bus, s.b);
        check({nm, "_lumin"}, {8'h0, l_bus}, {8'h0, s.l});
    endtask

    function automatic int step_to(input int c, input int t);
        if (c < t) return (t - c > STEP) ? c + STEP : t;
        if (c > t) return (c - t > STEP) ? c - STEP : t;
        return c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NM; i++) begin
            mr[i] = 0; mg[i] = 0; mb[i] = 0;
            tr[i] = 0; tg[i] = 0; t_b[i] = 0;
        end
    endfunction

    function automatic void model_scan();
        for (int i = 0; i < NM; i++) begin
            mr[i] = step_to(mr[i], tr[i]);
            mg[i] = step_to(mg[i], tg[i]);
            mb[i] = step_to(mb[i], t_b[i]);
        end
    endfunction

    function automatic snap_t mk_snap(input bit e);
        snap_t s;
        s = '0;
        for (int k = 0; k < N; k++) begin
            s.r[8*k +: 8] = 8'(mr[k]);
            s.g[8*k +: 8] = 8'(mg[k]);
            s.b[8*k +: 8] = 8'(mb[k]);
        end
        for (int j = 0; j < M; j++) s.l[8*j +: 8] = 8'(mr[N+j]);
        for (int i = 0; i < NM; i++)
            if (mr[i] != tr[i] || mg[i] != tg[i] || mb[i] != t_b[i])
                s.busy = 1'b1;
        s.err = e;
        return s;
    endfunction

    function automatic bit model_cmd(input int i, input int r, input int g,
                                     input int b, input int l,
                                     input bit inst);
        if (i < N) begin
            tr[i] = r; tg[i] = g; t_b[i] = b;
            if (inst) begin mr[i] = r; mg[i] = g; mb[i] = b; end
            return 1'b0;
        end
        if (i < NM) begin
            tr[i] = l;
            if (inst) mr[i] = l;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // called #1 after a rising edge; returns #1 after the accepting edge
    task automatic issue(input int i, input int r, input int g,
                         input int b, input int l, input bit inst);
        bit ok;
        bit e;
        ok = 0;
        idx = 3'(i); red = 8'(r); grn = 8'(g); blu = 8'(b);
        lum = 8'(l); instant = inst; valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        valid = 1'b0;
        if (!ok) begin
            check("cmd_accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model_cmd(i, r, g, b, l, inst);
            cmd_q.push_back(mk_snap(e));
        end
    endtask

    task automatic issue_rand();
        issue($urandom_range(0, 7), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 3) == 0);
    endtask

    task automatic wait_scan(input int rel_cyc);
        int start;
        start = scan_cnt;
        for (int n = 0; n < 400 && scan_cnt == start; n++) begin
            @(posedge clk);
            #1;
        end
        if (scan_cnt == start) check("scan_timeout", 32'd0, 32'd1);
        else if (rel_cyc >= 0)
            check("first_tick", 32'(last_drop), 32'(rel_cyc + PERIOD));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            snap_t s;
            if (busy_chk) begin
                check("busy", {31'd0, busy}, {31'd0, exp_busy});
                busy_chk = 0;
            end
            if (err_chk) begin
                check("err_one_cycle", {31'd0, err}, 32'd0);
                err_chk = 0;
            end
            if (acc_prev) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_queue_empty", 32'd0, 32'd1);
                end else begin
                    s = cmd_q.pop_front();
                    cmp_snap("cmd", s);
                    check("cmd_err", {31'd0, err}, {31'd0, s.err});
                    exp_busy = s.busy; busy_chk = 1; err_chk = 1;
                end
            end
            if (ready && !rdy_prev) begin
                check("scan_len", 32'(run), 32'(NM + 1));
                if (last_rise >= 0)
                    check("tick_period", 32'(cyc - last_rise), 32'(PERIOD));
                last_rise = cyc;
                if (scan_q.size() == 0) begin
                    check("scan_queue_empty", 32'd0, 32'd1);
                end else begin
                    s = scan_q.pop_front();
                    cmp_snap("scan", s);
                    exp_busy = s.busy; busy_chk = 1;
                end
                scan_cnt++;
            end
            if (!ready && rdy_prev) begin
                last_drop = cyc;
                run = 0;
            end
            if (!ready) run++;
            acc_prev = valid && ready;
            rdy_prev = ready;
        end
    end

    task automatic check_zero(input string nm);
        check({nm, "_red"}, r_bus, 32'd0);
        check({nm, "_green"}, g_bus, 32'd0);
        check({nm, "_blue"}, b_bus, 32'd0);
        check({nm, "_lumin"}, {8'h0, l_bus}, 32'd0);
        check({nm, "_busy"}, {31'd0, busy}, 32'd0);
        check({nm, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int rel_cyc;
        int tgt;
        model_reset();
        repeat (3) @(posedge clk);
        #1 srst_n = 1'b1;
        rel_cyc = cyc;
        @(posedge clk);
        #1;
        check_zero("reset");
        check("reset_ready", {31'd0, ready}, 32'd1);
        rdy_prev = 1; acc_prev = 0; last_rise = -1; mon_en = 1;

        issue(1, 8'hFF, 8'h10, 8'h00, 0, 1);
        repeat (2) @(posedge clk); #1;
        issue(5, 0, 0, 0, 8'h04, 0);
        repeat (2) @(posedge clk); #1;
        issue(0, 8'h0A, 0, 0, 0, 1);
        repeat (2) @(posedge clk); #1;
        issue(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk); #1;
        issue(7, 8'h55, 8'h66, 8'h77, 8'h88, 1);
        repeat (2) @(posedge clk); #1;

        for (int rnd = 0; rnd < 25; rnd++) begin
            model_scan();
            scan_q.push_back(mk_snap(1'b0));
            wait_scan(rnd == 0 ? rel_cyc : -1);
            repeat (10) @(posedge clk);
            #1;
            if (rnd >= 4) begin
                for (int c = $urandom_range(0, 3); c > 0; c--) begin
                    issue_rand();
                    repeat ($urandom_range(2, 5)) @(posedge clk);
                    #1;
                end
            end
            if (rnd % 4 == 1) begin
                tgt = last_drop + PERIOD - 1;
                while (cyc < tgt) begin
                    @(posedge clk);
                    #1;
                end
                issue_rand();
            end
        end

        tgt = last_drop + PERIOD + 3;
        while (cyc < tgt) begin
            @(posedge clk);
            #1;
        end
        mon_en = 0;
        srst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_scan_reset");
        srst_n = 1'b1;
        rel_cyc = cyc;
        cmd_q.delete();
        scan_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("post_reset");
        check("post_reset_ready", {31'd0, ready}, 32'd1);
        rdy_prev = 1; acc_prev = 0; busy_chk = 0; err_chk = 0;
        last_rise = -1; mon_en = 1;
        issue(6, 0, 0, 0, 8'h09, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            model_scan();
            scan_q.push_back(mk_snap(1'b0));
            wait_scan(s == 0 ? rel_cyc : -1);
        end
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
